n_term_loopback_bist: RTL and testbench



---
 rtl/n_term_bist_pkg.sv | 67 ++++++
 rtl/bist_lfsr52.sv | 36 +++
 rtl/n_term_loopback_bist.sv | 153 +++++++++++++++
 tb/tb_n_term_loopback_bist.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/n_term_bist_pkg.sv
// Shared constants, types and helpers for the north-terminal
// loopback BIST: wire groups, LFSR taps, FSM states.
package n_term_bist_pkg;

  localparam int WIRES = 52;

  localparam int S1_B  = 0;
  localparam int S1_W  = 4;
  localparam int S2_B  = 4;
  localparam int S2_W  = 8;
  localparam int S2B_B = 12;
  localparam int S2B_W = 8;
  localparam int S4_B  = 20;
  localparam int S4_W  = 16;
  localparam int SS4_B = 36;
  localparam int SS4_W = 16;

  // Galois right-shift form of x^52 + x^49 + 1.
  localparam int LFSR_W = 52;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 52'h9_0000_0000_0000;

  localparam logic [5:0] IDX_NONE = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_LFSR,
    ST_DONE
  } state_t;

  // The south terminal reverses bit order inside each group.
  function automatic logic [WIRES-1:0] expected_loopback(
    input logic [WIRES-1:0] drive
  );
    logic [WIRES-1:0] e;
    int b;
    int w;
    e = '0;
    for (int k = 0; k < WIRES; k++) begin
      if (k < S2_B) begin
        b = S1_B;  w = S1_W;
      end else if (k < S2B_B) begin
        b = S2_B;  w = S2_W;
      end else if (k < S4_B) begin
        b = S2B_B; w = S2B_W;
      end else if (k < SS4_B) begin
        b = S4_B;  w = S4_W;
      end else begin
        b = SS4_B; w = SS4_W;
      end
      e[6'(k)] = drive[6'(2 * b + w - 1 - k)];
    end
    return e;
  endfunction

  function automatic logic [5:0] lowest_set(
    input logic [WIRES-1:0] m
  );
    logic [5:0] r;
    r = IDX_NONE;
    for (int i = WIRES - 1; i >= 0; i--) begin
      if (m[6'(i)]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_lfsr52.sv
// 52-bit Galois LFSR pattern source: load seed, then advance
// once per pattern on request.
module bist_lfsr52
  import n_term_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 52'h0_0000_0000_0001
) (
  input  logic              UserCLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Load has priority; advance shifts right and folds in taps.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : '0);
    end
  end

  // State register.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/n_term_loopback_bist.sv
// North-edge loopback BIST: walking-one then LFSR patterns on
// S_BEG, checked against group-reversed N_END returns.
module n_term_loopback_bist
  import n_term_bist_pkg::*;
#(
  parameter int                NUM_PATTERNS  = 256,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [WIRES-1:0]  SEED          = 52'h0_0000_0000_0001
) (
  input  logic             UserCLK,
  input  logic             RESET,
  input  logic             start,
  output logic [WIRES-1:0] S_BEG,
  input  logic [WIRES-1:0] N_END,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [5:0]       first_err_idx,
  output logic [15:0]      first_err_pattern
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYCLES);
  localparam logic [15:0]   WALK_LAST  = 16'(WIRES - 1);
  localparam logic [15:0]   RUN_LAST   = 16'(WIRES + NUM_PATTERNS - 1);

  state_t           state_q, state_d;
  logic [15:0]      pat_q, pat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIRES-1:0] nend_q, nend_d;
  logic [15:0]      err_q, err_d;
  logic [5:0]       fidx_q, fidx_d;
  logic [15:0]      fpat_q, fpat_d;
  logic             done_q, done_d;

  logic             lfsr_load;
  logic             lfsr_adv;
  logic [WIRES-1:0] lfsr_state;
  logic [WIRES-1:0] drive;
  logic [WIRES-1:0] mism;

  bist_lfsr52 #(
    .SEED (SEED)
  ) u_lfsr (
    .UserCLK (UserCLK),
    .RESET   (RESET),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // Pattern on the wires follows the phase; quiet outside a run.
  always_comb begin
    drive = '0;
    unique case (state_q)
      ST_WALK: drive = {{(WIRES-1){1'b0}}, 1'b1} << pat_q[5:0];
      ST_LFSR: drive = lfsr_state;
      default: drive = '0;
    endcase
  end

  assign mism = nend_q ^ expected_loopback(drive);

  // Next-state: run control, settle timing, compare and results.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    nend_d    = nend_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    fpat_d    = fpat_q;
    done_d    = done_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WALK;
          pat_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fidx_d  = IDX_NONE;
          fpat_d  = '0;
          done_d  = 1'b0;
        end
      end
      ST_WALK, ST_LFSR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_SAMPLE) nend_d = N_END;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          pat_d = pat_q + 16'd1;
          if (|mism) begin
            if (err_q == 16'd0) begin
              fidx_d = lowest_set(mism);
              fpat_d = pat_q;
            end
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          if (state_q == ST_WALK) begin
            if (pat_q == WALK_LAST) begin
              state_d   = ST_LFSR;
              lfsr_load = 1'b1;
            end
          end else begin
            lfsr_adv = 1'b1;
            if (pat_q == RUN_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, capture and result registers.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      nend_q  <= '0;
      err_q   <= '0;
      fidx_q  <= IDX_NONE;
      fpat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      nend_q  <= nend_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fpat_q  <= fpat_d;
      done_q  <= done_d;
    end
  end

  assign S_BEG             = drive;
  assign busy              = (state_q == ST_WALK) ||
                             (state_q == ST_LFSR);
  assign done              = done_q;
  assign pass              = done_q && (err_q == 16'd0);
  assign err_count         = err_q;
  assign first_err_idx     = fidx_q;
  assign first_err_pattern = fpat_q;

endmodule

// File: tb/tb_n_term_loopback_bist.sv
// Directed bench for n_term_loopback_bist with a selectable
// south-terminal return model (ideal, faults, delay stages).
module tb_n_term_loopback_bist;

  logic        UserCLK;
  logic        RESET;
  logic        start;
  logic [51:0] S_BEG;
  logic [51:0] N_END;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [5:0]  first_err_idx;
  logic [15:0] first_err_pattern;

  int tests;
  int fails;
  int mode;

  logic [51:0] pipe0, pipe1, pipe2, pipe3;

  n_term_loopback_bist dut (
    .UserCLK           (UserCLK),
    .RESET             (RESET),
    .start             (start),
    .S_BEG             (S_BEG),
    .N_END             (N_END),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .first_err_idx     (first_err_idx),
    .first_err_pattern (first_err_pattern)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  function automatic logic [51:0] loopm(input logic [51:0] d);
    int gb [5];
    int gw [5];
    logic [51:0] e;
    gb = '{0, 4, 12, 20, 36};
    gw = '{4, 8, 8, 16, 16};
    e = '0;
    for (int g = 0; g < 5; g++)
      for (int i = 0; i < gw[g]; i++)
        e[6'(gb[g] + i)] = d[6'(gb[g] + gw[g] - 1 - i)];
    return e;
  endfunction

  always @(posedge UserCLK) begin
    pipe0 <= S_BEG;
    pipe1 <= pipe0;
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end

  // 0 ideal, 1 bit20 stuck-0, 2 swap 0/1, 3/4 reg stages, 5 ones
  always_comb begin
    N_END = loopm(S_BEG);
    case (mode)
      1: N_END[20] = 1'b0;
      2: begin
        N_END[0] = loopm(S_BEG) >> 1;
        N_END[1] = loopm(S_BEG);
      end
      3: N_END = loopm(pipe2);
      4: N_END = loopm(pipe3);
      5: N_END = '1;
      default: N_END = loopm(S_BEG);
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [51:0] s5, s255, s260, s265;
  logic        d1539;
  logic [15:0] e0;

  task automatic start_run();
    @(negedge UserCLK);
    start = 1'b1;
    @(posedge UserCLK);
    #1;
    start = 1'b0;
    e0 = err_count;
  endtask

  // n counts edges after the start edge; pattern p shows at 5p.
  task automatic wait_done(output int n, input int pulse_at);
    n = 0;
    d1539 = 1'bx;
    while (!done && n < 3000) begin
      @(posedge UserCLK);
      #1;
      n++;
      start = (n == pulse_at);
      if (n == 5)    s5    = S_BEG;
      if (n == 255)  s255  = S_BEG;
      if (n == 260)  s260  = S_BEG;
      if (n == 265)  s265  = S_BEG;
      if (n == 1539) d1539 = done;
    end
    start = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " S_BEG"}, S_BEG, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " err"}, err_count, 0);
    chk({tag, " fidx"}, first_err_idx, 63);
    chk({tag, " fpat"}, first_err_pattern, 0);
  endtask

  int n;

  initial begin
    tests = 0;
    fails = 0;
    mode  = 0;
    start = 1'b0;
    RESET = 1'b1;
    #12;
    chk_reset("rst");
    @(negedge UserCLK);
    RESET = 1'b0;

    // ideal loopback, full clean run
    start_run();
    chk("p0 busy", busy, 1);
    chk("p0 S_BEG", S_BEG, 52'h1);
    wait_done(n, -1);
    chk("ideal len", n, 1540);
    chk("ideal done@1539", d1539, 0);
    chk("walk p1", s5, 52'h2);
    chk("walk p51", s255, 52'h8_0000_0000_0000);
    chk("lfsr seed", s260, 52'h1);
    chk("lfsr step", s265, 52'h9_0000_0000_0000);
    chk("ideal pass", pass, 1);
    chk("ideal err", err_count, 0);
    chk("ideal fidx", first_err_idx, 63);
    chk("ideal busy", busy, 0);
    chk("ideal S_BEG", S_BEG, 0);

    // N_END[20] stuck low: first seen at walk bit 35
    mode = 1;
    start_run();
    wait_done(n, -1);
    chk("stk fpat", first_err_pattern, 35);
    chk("stk fidx", first_err_idx, 20);
    chk("stk pass", pass, 0);
    chk("stk err>0", err_count != 0, 1);

    // N_END[0]/[1] swapped: first seen at walk bit 2
    mode = 2;
    start_run();
    wait_done(n, -1);
    chk("swp fpat", first_err_pattern, 2);
    chk("swp fidx", first_err_idx, 0);
    chk("swp pass", pass, 0);

    // three register stages still settle in time
    mode = 3;
    start_run();
    wait_done(n, -1);
    chk("d3 pass", pass, 1);

    // four stages: pattern 0 sees an idle zero return
    mode = 4;
    start_run();
    wait_done(n, -1);
    chk("d4 pass", pass, 0);
    chk("d4 fpat", first_err_pattern, 0);
    chk("d4 fidx", first_err_idx, 3);

    // start while busy is ignored
    mode = 0;
    start_run();
    wait_done(n, 10);
    chk("ign len", n, 1540);
    chk("ign pass", pass, 1);

    // reset mid-run with errors accumulated
    mode = 5;
    start_run();
    repeat (100) @(posedge UserCLK);
    #1;
    chk("pre-rst err", err_count, 20);
    RESET = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge UserCLK);
    RESET = 1'b0;

    // fresh clean run after the abort
    mode = 0;
    start_run();
    wait_done(n, -1);
    chk("fresh len", n, 1540);
    chk("fresh pass", pass, 1);

    // all-ones return: every pattern fails
    mode = 5;
    start_run();
    wait_done(n, -1);
    chk("ones err", err_count, 308);
    chk("ones fpat", first_err_pattern, 0);
    chk("ones fidx", first_err_idx, 0);
    chk("ones pass", pass, 0);

    start_run();
    chk("ones2 clr", e0, 0);
    chk("ones2 done clr", done, 0);
    wait_done(n, -1);
    chk("ones2 err", err_count, 308);
    chk("ones2 len", n, 1540);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
